mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the core's instruction-fetch and load/store traffic. Accepts one request at a time from either the fetch port or the data port and returns a single-cycle done pulse after a fixed latency. It is the slave end of the core's memory_done handshake and contains the word-organised backing store. It also performs byte/half lane extraction with sign extension, and byte-enabled stores.

## Interface
Parameters:
- DEPTH_WORDS, 4096: storage depth in 32-bit words; power of two.
- LATENCY, 2: cycles from acceptance to done; legal range 1..15.
- INIT_FILE, "": hex image loaded at elaboration; empty means no load.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-low.
- if_req_i  in  1  fetch request; held until if_done_o.
- if_addr_i  in  32  fetch byte address.
- if_done_o  out  1  one-cycle fetch completion pulse.
- if_rdata_o  out  32  fetched word; valid while if_done_o=1.
- dm_req_i  in  1  data request; held until dm_done_o.
- dm_we_i  in  1  1 = store, 0 = load.
- dm_size_i  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- dm_unsigned_i  in  1  zero-extend loads when 1.
- dm_addr_i  in  32  data byte address.
- dm_wdata_i  in  32  store data, right-aligned.
- dm_done_o  out  1  one-cycle data completion pulse.
- dm_rdata_o  out  32  extended load data; valid while dm_done_o=1.
- err_o  out  1  misalignment flag, coincident with a done pulse.

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - dm_req_i=1 → latch data operands, owner=DATA.
  - Else if if_req_i=1 → latch fetch operands, owner=FETCH.
  - Data wins whenever both requests are high.
  - The latched operands are the only ones used; input changes after acceptance are ignored.
- Next state after acceptance:
  - LATENCY=1 → RESP.
  - LATENCY>1 → BUSY, with the counter loaded with LATENCY-2. The counter is 4 bits.
- BUSY: decrement the counter; go to RESP when the counter is 0.
- RESP:
  - Assert the owner's done for exactly one cycle.
  - Stores commit on the edge that ends RESP.
  - Next state is IDLE.
  - A request still high in the following IDLE cycle is treated as a new request.
- Word index = addr[log2(DEPTH_WORDS)+1:2]. Out-of-range addresses wrap modulo the depth.
- Loads:
  - Byte lane selected by addr[1:0]; half lane selected by addr[1].
  - Sign-extended, or zero-extended when dm_unsigned_i=1.
- Stores:
  - Byte: wdata[7:0] to lane addr[1:0].
  - Half: wdata[15:0] to lane addr[1].
  - Word: all four lanes.
  - Unselected bytes are unchanged.
- Stores return dm_rdata_o=0.
- rdata registers hold their value until the next done for the same port.

## Timing
- Reset (rst=0 at an edge):
  - State=IDLE, counter=0.
  - if_done_o=0, dm_done_o=0, err_o=0, if_rdata_o=0, dm_rdata_o=0.
  - Memory contents are not reset.
- Latency: a request accepted at edge N produces done high during cycle N+LATENCY (the cycle following edge N+LATENCY-1).
- Throughput: one access per LATENCY+1 cycles.
- Reset mid-operation: the in-flight access is abandoned. No done pulse, no write.
- Both requests high in IDLE: data is served first. Fetch is accepted in the IDLE cycle after the data RESP, provided it is still held.
- Done pulses never overlap; at most one of if_done_o and dm_done_o is high in any cycle.

## Configuration
- Macro: MEM_RESP_MISALIGN_ERR_EN.
- Defined:
  - Misaligned accesses are: fetch with addr[1:0]≠0, half with addr[0]=1, word with addr[1:0]≠0.
  - They complete with normal latency, with err_o=1 alongside done.
  - rdata=0 and no store is performed.
- Undefined:
  - Offending low address bits are forced to 0 and the access proceeds normally.
  - err_o is tied 0.

## Structure
- Shared package mem_pkg:
  - Size encodings SIZE_B, SIZE_H, SIZE_W.
  - FSM state enum.
  - Owner encoding.
- Sub-module mem_lane_align (combinational): load extract/extend and store byte-enable/lane-data generation. It is shared by the responder and the bench's reference model.
- Storage is a reg array inside mem_responder, initialised via $readmemh when INIT_FILE is non-empty.

## Test plan
- Reset: hold rst=0 for 3 cycles with both requests high → no done pulses and all outputs 0. Release rst → the data request is accepted first.
- Fetch, LATENCY=2: word[4]=0x00500093, if_req at addr 0x10 → if_done_o high exactly 2 cycles after acceptance, if_rdata_o=0x00500093.
- Byte store then loads: SB 0xAB to 0x21 → word[8]=0x0000AB00. LB from 0x21 → 0xFFFFFFAB; LBU → 0x000000AB.
- Half store: SH 0x8001 to 0x32, then LH from 0x32 → 0xFFFF8001 and word[12][15:0] unchanged.
- Arbitration: if_req and dm_req (load of 0x40) rise together → dm_done first, then if_done LATENCY+1 cycles later, never the same cycle.
- Misalign with macro: LW from 0x42 → dm_done with err_o=1, rdata=0. SW to 0x42 → word[16] unchanged. Without macro: LW from 0x42 returns word[16] and err_o=0.
- Reset mid-BUSY: SW 0xDEADBEEF, rst=0 one cycle before done → no done pulse, word unchanged.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the memory responder: access sizes, FSM states, request owner
// and the low-address-bit helpers used at acceptance.
package mem_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_e;

    // Fetches are presented as SIZE_W, so they share the word alignment rule.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SIZE_B:  return 1'b0;
            SIZE_H:  return lo[0];
            default: return lo != 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] align_lo(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SIZE_B:  return lo;
            SIZE_H:  return {lo[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: load byte/half extraction with sign/zero extension,
// and store byte-enables with lane-replicated write data.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rword_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [3:0]  be_o,
    output logic [31:0] wword_o
);

    logic [7:0]  lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane[gi] = rword_i[8*gi +: 8];
    end

    assign byte_sel = lane[addr_lo_i];
    assign half_sel = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];

    always_comb begin
        load_o  = rword_i;
        be_o    = 4'b1111;
        wword_o = wdata_i;
        case (size_i)
            SIZE_B: begin
                load_o  = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
                be_o    = 4'b0001 << addr_lo_i;
                wword_o = {4{wdata_i[7:0]}};
            end
            SIZE_H: begin
                load_o  = {{16{~unsigned_i & half_sel[15]}}, half_sel};
                be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wword_o = {2{wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with fixed latency and word-organised storage.
// Optional MEM_RESP_MISALIGN_ERR_EN: flag misaligned accesses on err_o instead of aligning them.
module mem_responder
    import mem_pkg::*;
#(
    parameter int    DEPTH_WORDS = 4096,
    parameter int    LATENCY     = 2,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_done_o,
    output logic [31:0] if_rdata_o,
    input  logic        dm_req_i,
    input  logic        dm_we_i,
    input  logic [1:0]  dm_size_i,
    input  logic        dm_unsigned_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_wdata_i,
    output logic        dm_done_o,
    output logic [31:0] dm_rdata_o,
    output logic        err_o
);

    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    logic [31:0] mem [DEPTH_WORDS];

    state_e      state_q, state_d;
    owner_e      owner_q, owner_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [AW+1:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] rd_word_q;
    logic [31:0] if_rdata_q, dm_rdata_q;

    logic [1:0]    req_size;
    logic [AW+1:0] req_addr;
    logic [31:0]   load_data, wword;
    logic [3:0]    be;
    logic [31:0]   if_resp, dm_resp;
    logic          resp_cycle;
    logic          unused_addr_hi;

    assign unused_addr_hi = ^{if_addr_i[31:AW+2], dm_addr_i[31:AW+2]};

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;

        req_size = SIZE_W;
        if (dm_req_i && dm_size_i != 2'b11) req_size = dm_size_i;
        req_addr = dm_req_i ? dm_addr_i[AW+1:0] : if_addr_i[AW+1:0];

        case (state_q)
            ST_IDLE: begin
                if (dm_req_i || if_req_i) begin
                    owner_d = dm_req_i ? OWN_DATA : OWN_FETCH;
                    we_d    = dm_req_i && dm_we_i;
                    size_d  = req_size;
                    uns_d   = dm_req_i && dm_unsigned_i;
                    wdata_d = dm_wdata_i;
`ifdef MEM_RESP_MISALIGN_ERR_EN
                    addr_d  = req_addr;
                    err_d   = is_misaligned(req_size, req_addr[1:0]);
`else
                    addr_d  = {req_addr[AW+1:2], align_lo(req_size, req_addr[1:0])};
                    err_d   = 1'b0;
`endif
                    if (LATENCY == 1) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            ST_BUSY: begin
                if (cnt_q == 4'd0) state_d = ST_RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_FETCH;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            size_q  <= SIZE_W;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    // Registered read follows the next-state address, so the word is ready by RESP even at LATENCY=1.
    always_ff @(posedge clk) begin
        rd_word_q <= mem[addr_d[AW+1:2]];
    end

    mem_lane_align u_align (
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .addr_lo_i  (addr_q[1:0]),
        .rword_i    (rd_word_q),
        .wdata_i    (wdata_q),
        .load_o     (load_data),
        .be_o       (be),
        .wword_o    (wword)
    );

    assign resp_cycle = (state_q == ST_RESP);

    // Reset on the closing edge of RESP abandons the store.
    always_ff @(posedge clk) begin
        if (rst && resp_cycle && owner_q == OWN_DATA && we_q && !err_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[addr_q[AW+1:2]][8*i +: 8] <= wword[8*i +: 8];
            end
        end
    end

    assign if_resp = err_q ? 32'd0 : rd_word_q;
    assign dm_resp = (err_q || we_q) ? 32'd0 : load_data;

    always_ff @(posedge clk) begin
        if (!rst) begin
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else if (resp_cycle) begin
            if (owner_q == OWN_FETCH) if_rdata_q <= if_resp;
            else                      dm_rdata_q <= dm_resp;
        end
    end

    assign if_done_o  = resp_cycle && owner_q == OWN_FETCH;
    assign dm_done_o  = resp_cycle && owner_q == OWN_DATA;
    assign if_rdata_o = if_done_o ? if_resp : if_rdata_q;
    assign dm_rdata_o = dm_done_o ? dm_resp : dm_rdata_q;
    assign err_o      = resp_cycle && err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: scoreboard of expected responses per request,
// covering reset, fetch, byte/half lanes, arbitration, misalignment and mid-flight reset.
module tb_mem_responder;

    localparam int LAT   = 2;
    localparam int DEPTH = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [1:0]  dm_size = 2'b10;
    logic        dm_uns = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic        dm_done;
    logic [31:0] dm_rdata;
    logic        err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          port;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        bit          d;
        bit          we;
        logic [1:0]  sz;
        bit          u;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        er;
    } op_t;

    exp_t        exp_q[$];
    logic [31:0] model_mem [int];

    mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT), .INIT_FILE("")) dut (
        .clk           (clk),
        .rst           (rst),
        .if_req_i      (if_req),
        .if_addr_i     (if_addr),
        .if_done_o     (if_done),
        .if_rdata_o    (if_rdata),
        .dm_req_i      (dm_req),
        .dm_we_i       (dm_we),
        .dm_size_i     (dm_size),
        .dm_unsigned_i (dm_uns),
        .dm_addr_i     (dm_addr),
        .dm_wdata_i    (dm_wdata),
        .dm_done_o     (dm_done),
        .dm_rdata_o    (dm_rdata),
        .err_o         (err)
    );

    always #5 clk = ~clk;

    function automatic op_t mk(bit d, bit we, logic [1:0] sz, bit u, logic [31:0] a,
                               logic [31:0] wd, logic [31:0] rd, logic er);
        op_t o;
        o.d = d; o.we = we; o.sz = sz; o.u = u; o.a = a; o.wd = wd; o.rd = rd; o.er = er;
        return o;
    endfunction

    function automatic int widx(logic [31:0] a);
        return int'((a >> 2) & (DEPTH - 1));
    endfunction

    function automatic logic [31:0] ref_load(logic [1:0] sz, bit u, logic [31:0] a);
        logic [31:0] w;
        logic [31:0] v;
        w = model_mem[widx(a)];
        case (sz)
            2'b00: begin
                v = (w >> (a[1:0] * 8)) & 32'hFF;
                if (!u && v[7]) v = v | 32'hFFFF_FF00;
            end
            2'b01: begin
                v = (w >> (a[1] * 16)) & 32'hFFFF;
                if (!u && v[15]) v = v | 32'hFFFF_0000;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic void ref_store(logic [1:0] sz, logic [31:0] a, logic [31:0] wd);
        logic [31:0] m;
        logic [31:0] d;
        case (sz)
            2'b00:   begin m = 32'hFF << (a[1:0] * 8);  d = (wd & 32'hFF) << (a[1:0] * 8); end
            2'b01:   begin m = 32'hFFFF << (a[1] * 16); d = (wd & 32'hFFFF) << (a[1] * 16); end
            default: begin m = 32'hFFFF_FFFF;           d = wd; end
        endcase
        model_mem[widx(a)] = (model_mem[widx(a)] & ~m) | (d & m);
    endfunction

    // Drives one request from an IDLE cycle, waits (bounded) for a done pulse, then
    // drops the request and steps one more cycle so the DUT is back in IDLE.
    task automatic run_req(input bit is_data, input bit we, input logic [1:0] sz, input bit u,
                           input logic [31:0] a, input logic [31:0] wd,
                           output int port, output logic [31:0] rd, output logic er, output int lat);
        port = 0; rd = '0; er = 1'b0; lat = 0;
        if (is_data) begin
            dm_req = 1'b1; dm_we = we; dm_size = sz; dm_uns = u; dm_addr = a; dm_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = a;
        end
        for (int k = 1; k <= 40 && port == 0; k++) begin
            @(posedge clk); #1;
            if (dm_done) begin
                port = 2; rd = dm_rdata; er = err; lat = k;
            end else if (if_done) begin
                port = 1; rd = if_rdata; er = err; lat = k;
            end
        end
        if_req = 1'b0;
        dm_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        int  dm_k, if_k;
        bit  overlap;
        rst = 1'b0;
        dm_req = 1'b1; dm_we = 1'b0; dm_size = 2'b10; dm_addr = 32'h40;
        if_req = 1'b1; if_addr = 32'h10;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++;
            if ({if_done, dm_done, err, if_rdata, dm_rdata} !== 67'd0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: got done=%b/%b err=%b if_rdata=%h dm_rdata=%h, required all zero",
                         c, if_done, dm_done, err, if_rdata, dm_rdata);
            end else $display("txn reset cycle %0d outputs zero", c);
        end
        rst = 1'b1;
        dm_k = 0; if_k = 0; overlap = 1'b0;
        for (int k = 1; k <= 30 && if_k == 0; k++) begin
            @(posedge clk); #1;
            if (if_done && dm_done) overlap = 1'b1;
            if (dm_done && dm_k == 0) begin dm_k = k; dm_req = 1'b0; end
            if (if_done && if_k == 0) begin if_k = k; if_req = 1'b0; end
        end
        if_req = 1'b0; dm_req = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (dm_k !== LAT || if_k !== LAT + LAT + 1 || overlap) begin
            errors++;
            $display("FAIL reset_release_order: got dm at %0d if at %0d overlap=%b, required dm at %0d if at %0d overlap=0",
                     dm_k, if_k, overlap, LAT, 2 * LAT + 1);
        end else $display("txn reset release: dm done at %0d, if done at %0d", dm_k, if_k);
    endtask

    task automatic test_ops(input string tname, input op_t ops[$]);
        int          port, lat;
        logic [31:0] rd;
        logic        er;
        exp_t        e;
        foreach (ops[i]) begin
            exp_q.push_back(exp_t'{port: ops[i].d ? 2 : 1, rdata: ops[i].rd, err: ops[i].er});
            run_req(ops[i].d, ops[i].we, ops[i].sz, ops[i].u, ops[i].a, ops[i].wd, port, rd, er, lat);
            e = exp_q.pop_front();
            checks++;
            if (port !== e.port || rd !== e.rdata || er !== e.err || lat !== LAT) begin
                errors++;
                $display("FAIL %s[%0d] addr=%h: got port=%0d rdata=%h err=%b lat=%0d, required port=%0d rdata=%h err=%b lat=%0d",
                         tname, i, ops[i].a, port, rd, er, lat, e.port, e.rdata, e.err, LAT);
            end else $display("txn %s[%0d] addr=%h rdata=%h err=%b", tname, i, ops[i].a, rd, er);
        end
    endtask

    task automatic test_fetch();
        op_t ops[$];
        ops.push_back(mk(1, 1, 2'b10, 0, 32'h10, 32'h0050_0093, 32'h0, 0));
        ops.push_back(mk(1, 1, 2'b10, 0, 32'h20, 32'h0000_0000, 32'h0, 0));
        ops.push_back(mk(1, 1, 2'b10, 0, 32'h30, 32'h1234_5678, 32'h0, 0));
        ops.push_back(mk(1, 1, 2'b10, 0, 32'h40, 32'hCAFE_F00D, 32'h0, 0));
        ops.push_back(mk(0, 0, 2'b10, 0, 32'h10, 32'h0,         32'h0050_0093, 0));
        test_ops("fetch", ops);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (if_rdata !== 32'h0050_0093 || if_done !== 1'b0) begin
            errors++;
            $display("FAIL fetch_hold: got if_rdata=%h if_done=%b, required 00500093 and 0", if_rdata, if_done);
        end else $display("txn fetch hold if_rdata=%h", if_rdata);
    endtask

    task automatic test_byte_half();
        op_t ops[$];
        ops.push_back(mk(1, 1, 2'b00, 0, 32'h21, 32'hFFFF_FFAB, 32'h0,         0));
        ops.push_back(mk(1, 0, 2'b10, 0, 32'h20, 32'h0,         32'h0000_AB00, 0));
        ops.push_back(mk(1, 0, 2'b00, 0, 32'h21, 32'h0,         32'hFFFF_FFAB, 0));
        ops.push_back(mk(1, 0, 2'b00, 1, 32'h21, 32'h0,         32'h0000_00AB, 0));
        ops.push_back(mk(1, 0, 2'b00, 0, 32'h20, 32'h0,         32'h0000_0000, 0));
        ops.push_back(mk(1, 1, 2'b01, 0, 32'h32, 32'h0000_8001, 32'h0,         0));
        ops.push_back(mk(1, 0, 2'b01, 0, 32'h32, 32'h0,         32'hFFFF_8001, 0));
        ops.push_back(mk(1, 0, 2'b01, 1, 32'h32, 32'h0,         32'h0000_8001, 0));
        ops.push_back(mk(1, 0, 2'b01, 0, 32'h30, 32'h0,         32'h0000_5678, 0));
        ops.push_back(mk(1, 0, 2'b11, 0, 32'h30, 32'h0,         32'h8001_5678, 0));
        test_ops("lanes", ops);
    endtask

    task automatic test_arbitration();
        int          dm_k, if_k;
        logic [31:0] dm_v, if_v;
        bit          overlap;
        dm_req = 1'b1; dm_we = 1'b0; dm_size = 2'b10; dm_uns = 1'b0; dm_addr = 32'h40;
        if_req = 1'b1; if_addr = 32'h10;
        dm_k = 0; if_k = 0; overlap = 1'b0; dm_v = '0; if_v = '0;
        for (int k = 1; k <= 30 && if_k == 0; k++) begin
            @(posedge clk); #1;
            if (if_done && dm_done) overlap = 1'b1;
            if (dm_done && dm_k == 0) begin dm_k = k; dm_v = dm_rdata; dm_req = 1'b0; end
            if (if_done && if_k == 0) begin if_k = k; if_v = if_rdata; if_req = 1'b0; end
        end
        if_req = 1'b0; dm_req = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (dm_k !== LAT || if_k !== 2 * LAT + 1 || overlap) begin
            errors++;
            $display("FAIL arb_order: got dm at %0d if at %0d overlap=%b, required dm at %0d if at %0d overlap=0",
                     dm_k, if_k, overlap, LAT, 2 * LAT + 1);
        end else $display("txn arb order dm=%0d if=%0d", dm_k, if_k);
        checks++;
        if (dm_v !== 32'hCAFE_F00D || if_v !== 32'h0050_0093) begin
            errors++;
            $display("FAIL arb_data: got dm=%h if=%h, required CAFEF00D and 00500093", dm_v, if_v);
        end else $display("txn arb data dm=%h if=%h", dm_v, if_v);
        checks++;
        if (dm_rdata !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL dm_hold: got %h, required CAFEF00D", dm_rdata);
        end else $display("txn dm hold %h", dm_rdata);
    endtask

    task automatic test_misalign();
        op_t ops[$];
`ifdef MEM_RESP_MISALIGN_ERR_EN
        ops.push_back(mk(1, 0, 2'b10, 0, 32'h42, 32'h0,         32'h0,         1));
        ops.push_back(mk(1, 1, 2'b10, 0, 32'h42, 32'h1111_1111, 32'h0,         1));
        ops.push_back(mk(1, 0, 2'b10, 0, 32'h40, 32'h0,         32'hCAFE_F00D, 0));
        ops.push_back(mk(1, 0, 2'b01, 0, 32'h41, 32'h0,         32'h0,         1));
        ops.push_back(mk(1, 0, 2'b00, 0, 32'h43, 32'h0,         32'hFFFF_FFCA, 0));
        ops.push_back(mk(0, 0, 2'b10, 0, 32'h12, 32'h0,         32'h0,         1));
`else
        ops.push_back(mk(1, 0, 2'b10, 0, 32'h42, 32'h0,         32'hCAFE_F00D, 0));
        ops.push_back(mk(1, 0, 2'b01, 0, 32'h41, 32'h0,         32'hFFFF_F00D, 0));
        ops.push_back(mk(1, 0, 2'b00, 0, 32'h43, 32'h0,         32'hFFFF_FFCA, 0));
        ops.push_back(mk(0, 0, 2'b10, 0, 32'h12, 32'h0,         32'h0050_0093, 0));
        ops.push_back(mk(1, 1, 2'b10, 0, 32'h52, 32'h1111_1111, 32'h0,         0));
        ops.push_back(mk(1, 0, 2'b10, 0, 32'h50, 32'h0,         32'h1111_1111, 0));
`endif
        test_ops("misalign", ops);
    endtask

    task automatic test_reset_mid();
        bit  seen;
        op_t ops[$];
        dm_req = 1'b1; dm_we = 1'b1; dm_size = 2'b10; dm_addr = 32'h40; dm_wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        rst = 1'b0;
        dm_req = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (if_done || dm_done || err) seen = 1'b1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_mid_done: got a done pulse after mid-flight reset, required none");
        end else $display("txn reset mid-flight, no done pulse");
        ops.push_back(mk(1, 0, 2'b10, 0, 32'h40, 32'h0, 32'hCAFE_F00D, 0));
        test_ops("reset_mid", ops);
    endtask

    task automatic test_back_to_back();
        op_t         ops[$];
        logic [31:0] a, wd;
        logic [1:0]  sz;
        bit          st, u;
        for (int i = 0; i < 8; i++) begin
            a  = 32'h100 + 32'(4 * i);
            wd = $urandom;
            ref_store(2'b10, a, wd);
            ops.push_back(mk(1, 1, 2'b10, 0, a, wd, 32'h0, 0));
        end
        for (int i = 0; i < 16; i++) begin
            sz = 2'($urandom_range(0, 2));
            a  = 32'h100 + 32'($urandom_range(0, 31));
            if (sz == 2'b01) a[0] = 1'b0;
            if (sz == 2'b10) a[1:0] = 2'b00;
            st = $urandom_range(0, 1) == 1;
            u  = $urandom_range(0, 1) == 1;
            wd = $urandom;
            if (st) begin
                ref_store(sz, a, wd);
                ops.push_back(mk(1, 1, sz, u, a, wd, 32'h0, 0));
            end else begin
                ops.push_back(mk(1, 0, sz, u, a, 32'h0, ref_load(sz, u, a), 0));
            end
        end
        wd = 32'h5A5A_0FF1;
        ref_store(2'b10, 32'h4104, wd);
        ops.push_back(mk(1, 1, 2'b10, 0, 32'h4104, wd, 32'h0, 0));
        for (int i = 0; i < 8; i++) begin
            a = 32'h100 + 32'(4 * i);
            ops.push_back(mk(1, 0, 2'b10, 0, a, 32'h0, ref_load(2'b10, 0, a), 0));
        end
        test_ops("b2b", ops);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fetch();
        test_byte_half();
        test_arbitration();
        test_misalign();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
